// File: rtl/phaethon_pkg.sv
// Shared constants, opcodes, FSM states and ALU helper for phaethon_alu.
// Optional feature macro: PHAETHON_DEBUG_EN (debug word register).
package phaethon_pkg;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NREG = 4;
  localparam int RIW  = 2;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOVI  = 8'h01;
  localparam logic [7:0] OP_MOV   = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_OR    = 8'h06;
  localparam logic [7:0] OP_XOR   = 8'h07;
  localparam logic [7:0] OP_LOAD  = 8'h08;
  localparam logic [7:0] OP_STORE = 8'h09;
  localparam logic [7:0] OP_JMP   = 8'h0A;
  localparam logic [7:0] OP_JZ    = 8'h0B;
  localparam logic [7:0] OP_HALT  = 8'h0C;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_EXEC,
    S_IMM_WAIT,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  // Register-register result; MOV passes B through.
  function automatic logic [DW-1:0] alu_f(
    input logic [7:0]    op,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-1:0] res;
    case (op)
      OP_MOV:  res = b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/phaethon_mem_port.sv
// Request/ack memory port: holds one read or write until accepted.
// Ports: i_rd/i_wr/i_addr/i_wdata command (idle only), o_accept, memory bus.
module phaethon_mem_port
  import phaethon_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_read_ack,
  input  logic          i_write_ack,
  output logic          o_accept,
  output logic          o_read_req,
  output logic          o_write_req,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata
);

  logic          r_rd;
  logic          r_wr;
  logic          r_armed;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          w_ack;
  logic          w_low;

  assign w_ack = (r_rd & i_read_ack) | (r_wr & i_write_ack);
  assign w_low = (r_rd & ~i_read_ack) | (r_wr & ~i_write_ack);

  // Only an ack seen low during this request counts; stale highs are ignored.
  assign o_accept = r_armed & w_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_armed <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (o_accept) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_armed <= 1'b0;
    end else if (r_rd | r_wr) begin
      if (w_low) r_armed <= 1'b1;
    end else if (i_rd | i_wr) begin
      r_rd   <= i_rd;
      r_wr   <= i_wr & ~i_rd;
      r_addr <= i_addr;
      if (i_wr & ~i_rd) r_data <= i_wdata;
    end
  end

  assign o_read_req  = r_rd;
  assign o_write_req = r_wr;
  assign o_addr      = r_addr;
  assign o_wdata     = r_data;

endmodule

// File: rtl/phaethon_alu.sv
// Phaethon execution core: fetch/decode/execute over a req/ack memory port.
// Ports: clk, reset (async low), memory bus, iPointer/opCode/r0/r1/debug.
// Macro PHAETHON_DEBUG_EN enables the debug word; otherwise debug is 0.
module phaethon_alu
  import phaethon_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ramValue,
  input  logic          readAck,
  input  logic          writeAck,
  output logic [AW-1:0] ramAddress,
  output logic [DW-1:0] ramOut,
  output logic          readReq,
  output logic          writeReq,
  output logic [AW-1:0] iPointer,
  output logic [7:0]    opCode,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] debug
);

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_regs [NREG];
  logic [RIW-1:0] r_a;
  logic [7:0]    r_b;
  logic [AW-1:0] r_ip;
  logic [7:0]    r_op;

  logic          w_accept;
  logic          w_rd;
  logic          w_wr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_ra;
  logic [DW-1:0] w_rb;
  logic [DW-1:0] w_alu;

  assign w_ra  = r_regs[r_a];
  assign w_rb  = r_regs[r_b[RIW-1:0]];
  assign w_alu = alu_f(r_op, w_ra, w_rb);

  phaethon_mem_port u_port (
    .clk         (clk),
    .reset       (reset),
    .i_rd        (w_rd),
    .i_wr        (w_wr),
    .i_addr      (w_addr),
    .i_wdata     (w_ra),
    .i_read_ack  (readAck),
    .i_write_ack (writeAck),
    .o_accept    (w_accept),
    .o_read_req  (readReq),
    .o_write_req (writeReq),
    .o_addr      (ramAddress),
    .o_wdata     (ramOut)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_addr = r_ip;
    unique case (r_state)
      S_FETCH: begin
        w_rd   = 1'b1;
        w_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: if (w_accept) w_next = S_EXEC;
      S_EXEC: begin
        case (r_op)
          OP_MOVI: begin
            w_rd   = 1'b1;
            w_addr = r_ip + 8'd4;
            w_next = S_IMM_WAIT;
          end
          OP_LOAD: begin
            w_rd   = 1'b1;
            w_addr = r_b;
            w_next = S_MEM_WAIT;
          end
          OP_STORE: begin
            w_wr   = 1'b1;
            w_addr = r_b;
            w_next = S_MEM_WAIT;
          end
          OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_XOR, OP_JMP, OP_JZ:
            w_next = S_FETCH;
          default: w_next = S_HALT;
        endcase
      end
      S_IMM_WAIT, S_MEM_WAIT: if (w_accept) w_next = S_FETCH;
      S_HALT: w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_ip <= '0;
      r_op <= '0;
    end else begin
      case (r_state)
        S_FETCH_WAIT: begin
          if (w_accept) begin
            r_op <= ramValue[7:0];
            r_a  <= ramValue[8 +: RIW];
            r_b  <= ramValue[23:16];
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_NOP: r_ip <= r_ip + 8'd4;
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              r_regs[r_a] <= w_alu;
              r_ip        <= r_ip + 8'd4;
            end
            OP_JMP: r_ip <= r_b;
            OP_JZ:  r_ip <= (w_ra == '0) ? r_b : r_ip + 8'd4;
            default: ;
          endcase
        end
        S_IMM_WAIT: begin
          if (w_accept) begin
            r_regs[r_a] <= ramValue;
            r_ip        <= r_ip + 8'd8;
          end
        end
        S_MEM_WAIT: begin
          if (w_accept) begin
            if (r_op == OP_LOAD) r_regs[r_a] <= ramValue;
            r_ip <= r_ip + 8'd4;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PHAETHON_DEBUG_EN
  logic [DW-1:0] r_debug;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_debug <= '0;
    end else begin
      case (r_state)
        S_EXEC: begin
          case (r_op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
              r_debug <= w_alu;
            default:
              if (r_op > OP_HALT) r_debug <= {24'hBAD000, r_op};
          endcase
        end
        S_IMM_WAIT, S_MEM_WAIT: begin
          if (w_accept)
            r_debug <= (r_op == OP_STORE) ? w_ra : ramValue;
        end
        default: ;
      endcase
    end
  end

  assign debug = r_debug;
`else
  assign debug = '0;
`endif

  assign iPointer = r_ip;
  assign opCode   = r_op;
  assign r0       = r_regs[0];
  assign r1       = r_regs[1];

endmodule

// File: tb/tb_phaethon_alu.sv
// Directed scoreboard bench for phaethon_alu with a req/ack memory model.
// The model can hold a stale ack high into the next request.
module tb_phaethon_alu;

  logic        clk;
  logic        reset;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  logic [7:0]  ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [7:0]  iPointer;
  logic [7:0]  opCode;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] debug;

  phaethon_alu dut (
    .clk        (clk),
    .reset      (reset),
    .ramValue   (ramValue),
    .readAck    (readAck),
    .writeAck   (writeAck),
    .ramAddress (ramAddress),
    .ramOut     (ramOut),
    .readReq    (readReq),
    .writeReq   (writeReq),
    .iPointer   (iPointer),
    .opCode     (opCode),
    .r0         (r0),
    .r1         (r1),
    .debug      (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model
  logic [7:0]  mem [256];
  int          hold;
  int          cnt;
  logic        ld_en;
  logic        ld_clr;
  logic [7:0]  ld_addr;
  logic [31:0] ld_word;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ld_en) begin
      mem[ld_addr]        <= ld_word[7:0];
      mem[ld_addr + 8'd1] <= ld_word[15:8];
      mem[ld_addr + 8'd2] <= ld_word[23:16];
      mem[ld_addr + 8'd3] <= ld_word[31:24];
    end else if (writeReq && reset && cnt == hold + 1) begin
      mem[ramAddress]        <= ramOut[7:0];
      mem[ramAddress + 8'd1] <= ramOut[15:8];
      mem[ramAddress + 8'd2] <= ramOut[23:16];
      mem[ramAddress + 8'd3] <= ramOut[31:24];
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      readAck  <= 1'b0;
      writeAck <= 1'b0;
      ramValue <= '0;
      cnt      <= 0;
    end else if (readReq || writeReq) begin
      cnt <= cnt + 1;
      if (cnt == hold) begin
        readAck  <= 1'b0;
        writeAck <= 1'b0;
      end else if (cnt == hold + 1) begin
        if (readReq) begin
          ramValue <= {mem[ramAddress + 8'd3], mem[ramAddress + 8'd2],
                       mem[ramAddress + 8'd1], mem[ramAddress]};
          readAck  <= 1'b1;
        end else begin
          writeAck <= 1'b1;
        end
      end
    end else begin
      cnt <= 0;
      if (hold > 0) ramValue <= 32'hDEADBEEF;
    end
  end

  logic overlap;
  initial overlap = 1'b0;
  always @(negedge clk) if (readReq && writeReq) overlap <= 1'b1;

`ifdef PHAETHON_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  function automatic logic [31:0] dbg(input logic [31:0] v);
    return DBG ? v : 32'h0;
  endfunction

  // scoreboard
  localparam int O_R0 = 0, O_R1 = 1, O_IP = 2, O_OP = 3, O_DBG = 4;
  localparam int O_MEM = 5, O_RRQ = 6, O_WRQ = 7, O_ADR = 8, O_OUT = 9;

  typedef struct {
    string       tag;
    int          sel;
    logic [7:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] observe(input int sel, input logic [7:0] a);
    case (sel)
      O_R0:  return r0;
      O_R1:  return r1;
      O_IP:  return {24'h0, iPointer};
      O_OP:  return {24'h0, opCode};
      O_DBG: return debug;
      O_MEM: return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
      O_RRQ: return {31'h0, readReq};
      O_WRQ: return {31'h0, writeReq};
      O_ADR: return {24'h0, ramAddress};
      default: return ramOut;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input int sel,
                      input logic [31:0] v, input logic [7:0] a = 8'h0);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = a; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel, e.addr), e.val);
    end
  endtask

  task automatic begin_prog();
    @(negedge clk);
    reset  = 1'b0;
    ld_clr = 1'b1;
    @(posedge clk);
    #1 ld_clr = 1'b0;
  endtask

  task automatic putw(input logic [7:0] a, input logic [31:0] w);
    ld_addr = a;
    ld_word = w;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input string tag);
    int idle = 0;
    int n = 0;
    while (idle < 12 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!readReq && !writeReq) idle++;
      else idle = 0;
    end
    chk(tag, {31'h0, n < 3000}, 32'h1);
  endtask

  initial begin
    int rises;
    logic prev;
    int n;
    reset  = 1'b0;
    hold   = 0;
    ld_en  = 1'b0;
    ld_clr = 1'b0;
    ld_addr = '0;
    ld_word = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_rreq", O_RRQ, 0);
    push("rst_wreq", O_WRQ, 0);
    push("rst_addr", O_ADR, 0);
    push("rst_out",  O_OUT, 0);
    push("rst_ip",   O_IP,  0);
    push("rst_op",   O_OP,  0);
    push("rst_r0",   O_R0,  0);
    push("rst_r1",   O_R1,  0);
    push("rst_dbg",  O_DBG, 0);
    check_all();

    // MOVI r0,0x12345678 ; HALT
    begin_prog();
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'h1234_5678);
    putw(8'h08, 32'h0000_000C);
    go();
    @(posedge clk);
    #1;
    push("first_rreq", O_RRQ, 1);
    push("first_addr", O_ADR, 0);
    check_all();
    push("movi_r0",  O_R0,  32'h1234_5678);
    push("movi_ip",  O_IP,  8);
    push("movi_op",  O_OP,  8'h0C);
    push("movi_dbg", O_DBG, dbg(32'h1234_5678));
    run_to_halt("movi_halt");
    check_all();

    // MOVI r0,5 ; MOVI r1,3 ; SUB r0,r1 ; HALT
    begin_prog();
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'd5);
    putw(8'h08, 32'h0000_0101);
    putw(8'h0C, 32'd3);
    putw(8'h10, 32'h0001_0004);
    putw(8'h14, 32'h0000_000C);
    go();
    push("sub_r0",  O_R0,  2);
    push("sub_r1",  O_R1,  3);
    push("sub_ip",  O_IP,  8'h14);
    push("sub_dbg", O_DBG, dbg(2));
    run_to_halt("sub_halt");
    check_all();

    // ADD wrap: 0xFFFFFFFF + 1
    begin_prog();
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'hFFFF_FFFF);
    putw(8'h08, 32'h0000_0101);
    putw(8'h0C, 32'd1);
    putw(8'h10, 32'h0001_0003);
    putw(8'h14, 32'h0000_000C);
    go();
    push("add_r0", O_R0, 0);
    push("add_r1", O_R1, 1);
    run_to_halt("add_halt");
    check_all();

    // STORE [0x40],r0 ; LOAD r1,[0x40]
    begin_prog();
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'hA1B2_C3D4);
    putw(8'h08, 32'h0040_0009);
    putw(8'h0C, 32'h0040_0108);
    putw(8'h10, 32'h0000_000C);
    go();
    push("st_mem", O_MEM, 32'hA1B2_C3D4, 8'h40);
    push("ld_r1",  O_R1,  32'hA1B2_C3D4);
    push("ld_ip",  O_IP,  8'h10);
    push("ld_dbg", O_DBG, dbg(32'hA1B2_C3D4));
    run_to_halt("ldst_halt");
    check_all();
    chk("st_byte40", {24'h0, mem[8'h40]}, 32'hD4);
    chk("st_byte43", {24'h0, mem[8'h43]}, 32'hA1);

    // JZ taken (r0 = 0)
    begin_prog();
    putw(8'h00, 32'h0020_000B);
    putw(8'h04, 32'h0000_00FF);
    putw(8'h20, 32'h0000_000C);
    go();
    push("jz_t_ip", O_IP, 8'h20);
    push("jz_t_op", O_OP, 8'h0C);
    run_to_halt("jz_t_halt");
    check_all();

    // JZ not taken (r0 = 1)
    begin_prog();
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'd1);
    putw(8'h08, 32'h0020_000B);
    putw(8'h0C, 32'h0000_000C);
    putw(8'h20, 32'h0000_00FF);
    go();
    push("jz_n_ip", O_IP, 8'h0C);
    push("jz_n_op", O_OP, 8'h0C);
    push("jz_n_dbg", O_DBG, dbg(1));
    run_to_halt("jz_n_halt");
    check_all();

    // NOP ; JMP 0 loops forever
    begin_prog();
    putw(8'h00, 32'h0000_0000);
    putw(8'h04, 32'h0000_000A);
    go();
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (readReq && !prev && ramAddress == 8'h00) rises++;
      prev = readReq;
    end
    chk("jmp_loops", {31'h0, rises >= 10}, 32'h1);

    // stale ack held high into each new request
    begin_prog();
    hold = 3;
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'h0000_0077);
    putw(8'h08, 32'h0000_000C);
    go();
    push("stale_r0", O_R0, 32'h77);
    push("stale_ip", O_IP, 8);
    push("stale_op", O_OP, 8'h0C);
    run_to_halt("stale_halt");
    check_all();
    hold = 0;

    // unknown opcode halts
    begin_prog();
    putw(8'h00, 32'h0000_00FF);
    go();
    run_to_halt("bad_halt");
    repeat (20) @(negedge clk);
    push("bad_op",   O_OP,  8'hFF);
    push("bad_ip",   O_IP,  0);
    push("bad_rreq", O_RRQ, 0);
    push("bad_wreq", O_WRQ, 0);
    push("bad_dbg",  O_DBG, dbg(32'hBAD0_00FF));
    check_all();

    // reset mid-fetch
    begin_prog();
    putw(8'h00, 32'h0000_0001);
    putw(8'h04, 32'h0000_0055);
    putw(8'h08, 32'h0008_000A);
    go();
    n = 0;
    while (!(r0 == 32'h55 && readReq) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", {31'h0, n < 500}, 32'h1);
    reset = 1'b0;
    #1;
    push("mid_rreq", O_RRQ, 0);
    push("mid_addr", O_ADR, 0);
    push("mid_ip",   O_IP,  0);
    push("mid_op",   O_OP,  0);
    push("mid_r0",   O_R0,  0);
    push("mid_dbg",  O_DBG, 0);
    check_all();

    chk("no_overlap", {31'h0, overlap}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
